// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sequencer
//  Purpose  : Bus-master sequencer for an 8-bit single-port scratch memory.
//             Executes one block command at a time (fill, copy, checksum)
//             behind a start/busy/done handshake. All memory-side outputs
//             are registered, so they stay stable for a whole write cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0]      c_OP_FILL = 2'b00;
  localparam logic [1:0]      c_OP_COPY = 2'b01;
  localparam logic [1:0]      c_OP_SUM  = 2'b10;
  localparam logic [1:0]      c_OP_NOP  = 2'b11;
  localparam logic [ADDR_W:0] c_IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_CP_RD = 3'd2,
    S_CP_WR = 3'd3,
    S_SUM   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W:0]     r_idx;
  logic [DATA_W-1:0]   r_result;
  logic                r_busy;
  logic                r_done;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  // During FILL this holds the fill byte; during CP_WR it is the copy hold
  // register (byte captured in the preceding CP_RD cycle).
  logic [DATA_W-1:0]   r_wdata;

  logic [ADDR_W:0]     w_idx_nxt;
  logic [ADDR_W:0]     w_len_m1;
  logic                w_last;
  logic                w_degen;
  logic [ADDR_W-1:0]   w_src_nxt;
  logic [ADDR_W-1:0]   w_dst_cur;
  logic [ADDR_W-1:0]   w_dst_nxt;

  // Index arithmetic; address sums wrap naturally at ADDR_W bits.
  assign w_idx_nxt = r_idx + c_IDX_ONE;
  assign w_len_m1  = {1'b0, r_len} - c_IDX_ONE;
  assign w_last    = (r_idx == w_len_m1);
  assign w_degen   = (len == '0) || (op == c_OP_NOP);
  assign w_src_nxt = r_src + w_idx_nxt[ADDR_W-1:0];
  assign w_dst_cur = r_dst + r_idx[ADDR_W-1:0];
  assign w_dst_nxt = r_dst + w_idx_nxt[ADDR_W-1:0];

  // Command FSM; memory-side outputs are loaded one cycle ahead so each
  // state sees its address/data/we already settled in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we    <= 1'b0;
          r_wdata <= '0;
          if (start) begin
            r_src    <= src;
            r_dst    <= dst;
            r_len    <= len;
            r_idx    <= '0;
            r_result <= '0;
            r_busy   <= 1'b1;
            if (w_degen) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              case (op)
                c_OP_FILL: begin
                  r_state <= S_FILL;
                  r_we    <= 1'b1;
                  r_addr  <= dst;
                  r_wdata <= fill;
                end
                c_OP_COPY: begin
                  r_state <= S_CP_RD;
                  r_addr  <= src;
                end
                default: begin
                  r_state <= S_SUM;
                  r_addr  <= src;
                end
              endcase
            end
          end
        end

        S_FILL: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_we    <= 1'b0;
            r_wdata <= '0;
          end else begin
            r_idx  <= w_idx_nxt;
            r_addr <= w_dst_nxt;
          end
        end

        S_CP_RD: begin
          r_state  <= S_CP_WR;
          r_result <= r_result + mem_rdata;
          r_wdata  <= mem_rdata;
          r_we     <= 1'b1;
          r_addr   <= w_dst_cur;
        end

        S_CP_WR: begin
          r_we    <= 1'b0;
          r_wdata <= '0;
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_CP_RD;
            r_idx   <= w_idx_nxt;
            r_addr  <= w_src_nxt;
          end
        end

        S_SUM: begin
          r_result <= r_result + mem_rdata;
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx  <= w_idx_nxt;
            r_addr <= w_src_nxt;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end

        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
          r_wdata <= '0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign mem_we      = r_we;
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_sequencer
//  Purpose  : Directed bench for mem_sequencer with write/done scoreboards
//             and a reference memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] src = 8'h00, dst = 8'h00, len = 8'h00, fill = 8'h00;
  logic       busy, done, mem_we;
  logic [7:0] result, mem_address, mem_wdata, mem_rdata;

  mem_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .fill(fill), .busy(busy), .done(done), .result(result),
    .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scratch memory: level write enable, combinational read, plus a bench
  // preload port. model[] holds what memory contents should be.
  logic [7:0] mem   [256];
  logic [7:0] model [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_a = 8'h00, pl_d = 8'h00;
  assign mem_rdata = mem[mem_address];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;
    forever begin
      @(mem_we or mem_address or mem_wdata or pl_we);
      if (mem_we) mem[mem_address] = mem_wdata;
      else if (pl_we) mem[pl_a] = pl_d;
    end
  end

  typedef struct { logic [7:0] res; int cyc; } done_t;
  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  done_t done_q[$];
  wr_t   wr_q[$];

  int total = 0;
  int bad   = 0;
  logic [7:0] last_res = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every write and every done pulse must match the queues.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) chk("spurious_write", mem_we, 0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", mem_address, w.a);
        chk("wr_data", mem_wdata, w.d);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) chk("spurious_done", done, 0);
      else begin
        done_t e;
        e = done_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_result", result, e.res);
        chk("done_busy", busy, 1);
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_a = a; pl_d = d; pl_we = 1'b1;
    #0.5 pl_we = 1'b0;
    #0.5;
    model[a] = d;
  endtask

  // Push expected writes/done for one command, applying it to the model.
  task automatic expect_cmd(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input logic [7:0] f, input int e0);
    int n;
    logic [7:0] sum, a, v;
    sum = 8'h00;
    if (l == 8'h00 || o == 2'b11) n = 1;
    else if (o == 2'b00) begin
      n = int'(l) + 1;
      for (int i = 0; i < int'(l); i++) begin
        a = d + 8'(i); model[a] = f; wr_q.push_back('{a, f});
      end
    end else if (o == 2'b01) begin
      n = 2 * int'(l) + 1;
      for (int i = 0; i < int'(l); i++) begin
        v = model[s + 8'(i)]; a = d + 8'(i);
        model[a] = v; wr_q.push_back('{a, v}); sum = sum + v;
      end
    end else begin
      n = int'(l) + 1;
      for (int i = 0; i < int'(l); i++) sum = sum + model[s + 8'(i)];
    end
    done_q.push_back('{sum, e0 + n - 1});
    last_res = sum;
  endtask

  task automatic issue(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input logic [7:0] f);
    @(negedge clk);
    op = o; src = s; dst = d; len = l; fill = f; start = 1'b1;
    expect_cmd(o, s, d, l, f, cyc + 1);
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && (done_q.size() > 0 || wr_q.size() > 0); k++) @(negedge clk);
    chk({tag, "_drain"}, done_q.size() + wr_q.size(), 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_result_hold"}, result, last_res);
  endtask

  task automatic mem_cmp(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) nbad++;
    chk({tag, "_mem"}, nbad, 0);
  endtask

  initial begin
    int e0;
    for (int i = 0; i < 256; i++) model[i] = 8'(i) ^ 8'h5C;

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fill 0x20..0x23 with 0xA5
    issue(2'b00, 8'h00, 8'h20, 8'd4, 8'hA5);
    drain("fill");
    mem_cmp("fill");
    chk("fill_0x1F", mem[8'h1F], 8'h1F ^ 8'h5C);
    chk("fill_0x24", mem[8'h24], 8'h24 ^ 8'h5C);

    // Checksum with overflow
    @(negedge clk);
    preload(8'h10, 8'h01); preload(8'h11, 8'h02); preload(8'h12, 8'hFF); preload(8'h13, 8'h03);
    issue(2'b10, 8'h10, 8'h00, 8'd4, 8'h00);
    drain("sum");
    chk("sum_value", result, 8'h05);

    // Copy with source wrap
    @(negedge clk);
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h22); preload(8'h00, 8'h33); preload(8'h01, 8'h44);
    issue(2'b01, 8'hFE, 8'h40, 8'd4, 8'h00);
    drain("copy");
    mem_cmp("copy");
    chk("copy_value", result, 8'hAA);

    // Overlapping ascending copy
    issue(2'b01, 8'h40, 8'h41, 8'd3, 8'h00);
    drain("ovl");
    mem_cmp("ovl");

    // Degenerate commands
    issue(2'b00, 8'h00, 8'h30, 8'd0, 8'h77); drain("len0_fill");
    issue(2'b01, 8'h10, 8'h30, 8'd0, 8'h00); drain("len0_copy");
    issue(2'b10, 8'h10, 8'h30, 8'd0, 8'h00); drain("len0_sum");
    issue(2'b11, 8'h10, 8'h30, 8'd5, 8'h77); drain("op3");
    mem_cmp("degen");

    // Handshake: start held for 20 edges; fields change while busy
    @(negedge clk);
    op = 2'b00; src = 8'h00; dst = 8'h80; len = 8'd3; fill = 8'hC3; start = 1'b1;
    e0 = cyc + 1;
    expect_cmd(2'b00, 8'h00, 8'h80, 8'd3, 8'hC3, e0);
    for (int b = 0; b < 4; b++) expect_cmd(2'b00, 8'h00, 8'h60, 8'd2, 8'h3C, e0 + 5 + 4 * b);
    @(posedge clk); #1;
    chk("hs_busy", busy, 1);
    @(negedge clk);
    dst = 8'h60; len = 8'd2; fill = 8'h3C;
    repeat (19) @(posedge clk);
    #1 start = 1'b0;
    drain("hs");
    mem_cmp("hs");

    // Reset abort in the second write cycle of a len=8 fill
    @(negedge clk);
    op = 2'b00; dst = 8'h00; len = 8'd8; fill = 8'h5A; start = 1'b1;
    wr_q.push_back('{8'h00, 8'h5A}); model[8'h00] = 8'h5A;
    wr_q.push_back('{8'h01, 8'h5A}); model[8'h01] = 8'h5A;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_queues", done_q.size() + wr_q.size(), 0);
    mem_cmp("abort");

    // Recovery after abort
    issue(2'b00, 8'h00, 8'h02, 8'd1, 8'h77);
    drain("recover");
    mem_cmp("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
